// File: rtl/id_operand_issue.sv
// Decode-stage operand issue: ID pipeline register, priority bypass over a
// generic set of producer channels, load-use interlock and perf counters.
module id_operand_issue #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_inst,
  output logic                    id_allow_in,
  output logic [XLEN-1:0]         id_pc,
  output logic [31:0]             id_inst,
  input  logic                    rs1_en,
  input  logic                    rs2_en,
  output logic [RA_W-1:0]         rf_raddr1,
  output logic [RA_W-1:0]         rf_raddr2,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [NUM_FWD-1:0]      fwd_ready,
  input  logic [NUM_FWD*RA_W-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic                    hold,
  input  logic                    flush,
  input  logic                    out_allow_in,
  output logic                    out_valid,
  output logic [XLEN-1:0]         out_rs1,
  output logic [XLEN-1:0]         out_rs2,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        hazard_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            id_valid;
  logic            haz1;
  logic            haz2;
  logic            hazard;
  logic            ready_go;
  logic [XLEN:0]   res1;
  logic [XLEN:0]   res2;

  // Returns {hazard, operand}. Channels are scanned oldest to youngest so the
  // lowest-index match overwrites any older one; x0 is forced last.
  function automatic logic [XLEN:0] resolve(
    input logic [RA_W-1:0]         rs,
    input logic [XLEN-1:0]         rf,
    input logic [NUM_FWD-1:0]      f_valid,
    input logic [NUM_FWD-1:0]      f_we,
    input logic [NUM_FWD-1:0]      f_ready,
    input logic [NUM_FWD*RA_W-1:0] f_addr,
    input logic [NUM_FWD*XLEN-1:0] f_data
  );
    logic [XLEN:0]   r;
    logic [RA_W-1:0] a;
    r = {1'b0, rf};
    for (int unsigned i = NUM_FWD; i > 0; i--) begin
      a = f_addr[(i-1)*RA_W +: RA_W];
      if (f_valid[i-1] && f_we[i-1] && (a != '0) && (a == rs)) begin
        r = {!f_ready[i-1], f_data[(i-1)*XLEN +: XLEN]};
      end
    end
    if (rs == '0) begin
      r = '0;
    end
    return r;
  endfunction

  assign rf_raddr1 = id_inst[15 +: RA_W];
  assign rf_raddr2 = id_inst[20 +: RA_W];

  always_comb begin
    res1 = resolve(rf_raddr1, rf_rdata1, fwd_valid, fwd_we, fwd_ready, fwd_addr, fwd_data);
    res2 = resolve(rf_raddr2, rf_rdata2, fwd_valid, fwd_we, fwd_ready, fwd_addr, fwd_data);
  end

  assign haz1        = res1[XLEN];
  assign haz2        = res2[XLEN];
  assign out_rs1     = res1[XLEN-1:0];
  assign out_rs2     = res2[XLEN-1:0];

  assign hazard      = id_valid && ((rs1_en && haz1) || (rs2_en && haz2));
  assign ready_go    = !hazard && !hold;
  assign id_allow_in = !id_valid || (ready_go && out_allow_in);
  assign out_valid   = id_valid && ready_go && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_inst  <= NOP;
    end else begin
      if (flush) begin
        id_valid <= 1'b0;
      end else if (id_allow_in) begin
        id_valid <= in_valid;
      end
      if (id_allow_in && in_valid && !flush) begin
        id_pc   <= in_pc;
        id_inst <= in_inst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      stall_cnt  <= '0;
      hazard_cnt <= '0;
    end else begin
      if (id_valid && !ready_go && !flush && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (hazard && (hazard_cnt != '1)) begin
        hazard_cnt <= hazard_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_operand_issue.sv
// Scoreboarded bench for id_operand_issue: directed scenarios plus random
// traffic, checked against a cycle-level reference model of the stage.
module tb_id_operand_issue;

  localparam int XL = 32;
  localparam int NF = 3;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [XL-1:0]    in_pc;
  logic [31:0]      in_inst;
  logic             id_allow_in;
  logic [XL-1:0]    id_pc;
  logic [31:0]      id_inst;
  logic             rs1_en;
  logic             rs2_en;
  logic [AW-1:0]    rf_raddr1;
  logic [AW-1:0]    rf_raddr2;
  logic [XL-1:0]    rf_rdata1;
  logic [XL-1:0]    rf_rdata2;
  logic [NF-1:0]    fwd_valid;
  logic [NF-1:0]    fwd_we;
  logic [NF-1:0]    fwd_ready;
  logic [NF*AW-1:0] fwd_addr;
  logic [NF*XL-1:0] fwd_data;
  logic             hold;
  logic             flush;
  logic             out_allow_in;
  logic             out_valid;
  logic [XL-1:0]    out_rs1;
  logic [XL-1:0]    out_rs2;
  logic             clr_cnt;
  logic [CW-1:0]    stall_cnt;
  logic [CW-1:0]    hazard_cnt;

  id_operand_issue #(.XLEN(XL), .NUM_FWD(NF), .RA_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .id_allow_in(id_allow_in), .id_pc(id_pc), .id_inst(id_inst),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_ready(fwd_ready),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .hold(hold), .flush(flush), .out_allow_in(out_allow_in),
    .out_valid(out_valid), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .clr_cnt(clr_cnt), .stall_cnt(stall_cnt), .hazard_cnt(hazard_cnt)
  );

  // Register file environment: combinational read of the bench's array.
  logic [31:0] regs [32];
  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] a; logic [31:0] b; } rec_t;
  rec_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic          m_known = 1'b0;
  logic          m_valid;
  logic [31:0]   m_pc;
  logic [31:0]   m_inst;
  logic [CW-1:0] m_stall;
  logic [CW-1:0] m_haz;
  logic          e_haz, e_go, e_allow, e_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void resolve(input logic [4:0] rs, output logic [31:0] v, output logic h);
    v = regs[rs];
    h = 1'b0;
    if (rs == 5'd0) begin
      v = 32'd0;
      return;
    end
    for (int i = 0; i < NF; i++) begin
      if (fwd_valid[i] && fwd_we[i] && fwd_addr[i*AW +: AW] == rs) begin
        v = fwd_data[i*XL +: XL];
        h = !fwd_ready[i];
        break;
      end
    end
  endfunction

  task automatic eval_model();
    logic [31:0] a, b;
    logic h1, h2;
    resolve(m_inst[19:15], a, h1);
    resolve(m_inst[24:20], b, h2);
    e_haz   = m_valid && ((rs1_en && h1) || (rs2_en && h2));
    e_go    = !e_haz && !hold;
    e_allow = !m_valid || (e_go && out_allow_in);
    e_out   = m_valid && e_go && !flush;
    if (m_known) begin
      chk("id_allow_in", 32'(id_allow_in), 32'(e_allow));
      chk("id_pc", id_pc, m_pc);
      chk("id_inst", id_inst, m_inst);
      chk("rf_raddr1", 32'(rf_raddr1), 32'(m_inst[19:15]));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("hazard_cnt", 32'(hazard_cnt), 32'(m_haz));
      if (e_out) q.push_back('{pc: m_pc, a: a, b: b});
    end
  endtask

  task automatic update_model();
    if (!rst_n) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_pc    = 32'd0;
      m_inst  = 32'h0000_0013;
      m_stall = '0;
      m_haz   = '0;
    end else begin
      if (e_allow && in_valid && !flush) begin
        m_pc   = in_pc;
        m_inst = in_inst;
      end
      if (clr_cnt) begin
        m_stall = '0;
        m_haz   = '0;
      end else begin
        if (m_valid && !e_go && !flush) m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1'b1;
        if (e_haz) m_haz = (m_haz == CMAX) ? CMAX : m_haz + 1'b1;
      end
      if (flush) m_valid = 1'b0;
      else if (e_allow) m_valid = in_valid;
    end
  endtask

  task automatic step();
    #1;
    eval_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = 32'h0000_0013;
    rs1_en = 1'b1; rs2_en = 1'b1; hold = 1'b0; flush = 1'b0;
    out_allow_in = 1'b1; clr_cnt = 1'b0;
    fwd_valid = '0; fwd_we = '0; fwd_ready = '0; fwd_addr = '0; fwd_data = '0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
    idle();
    in_valid = 1'b1; in_pc = pc; in_inst = inst;
    step();
  endtask

  // Monitor: every issue the DUT presents must match the oldest expected one.
  initial begin
    rec_t r;
    logic exp_v;
    forever begin
      @(negedge clk);
      if (m_known) begin
        exp_v = (q.size() != 0);
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        if (exp_v) begin
          r = q.pop_front();
          if (out_valid === 1'b1) begin
            chk("issue_pc", id_pc, r.pc);
            chk("out_rs1", out_rs1, r.a);
            chk("out_rs2", out_rs2, r.b);
          end
        end
        q.delete();
      end
    end
  end

  initial begin
    logic [31:0] inst;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'h0000_DEAD;
    idle();
    rst_n = 1'b0;
    step();
    step();

    // Back-to-back ADD x3,x1,x2 with no producers
    for (int k = 0; k < 3; k++) fetch(32'(k * 4), 32'h0020_81B3);
    idle();
    step();
    step();
    #1 chk("b2b_stall_cnt", 32'(stall_cnt), 32'd0);

    // Youngest matching producer wins: rs1=5 on channels 0 and 2
    fetch(32'h10, 32'h0062_80B3);
    idle();
    fwd_valid = 3'b101; fwd_we = 3'b101; fwd_ready = 3'b101;
    fwd_addr[0*AW +: AW] = 5'd5; fwd_addr[2*AW +: AW] = 5'd5;
    fwd_data[0*XL +: XL] = 32'hAAAA; fwd_data[2*XL +: XL] = 32'hBBBB;
    #1 chk("youngest_wins", out_rs1, 32'hAAAA);
    step();

    // Load-use on rs2=7: one cycle not ready, then ready with 0x1234
    idle(); clr_cnt = 1'b1; step();
    fetch(32'h20, 32'h0070_00B3);
    idle();
    fwd_valid = 3'b001; fwd_we = 3'b001; fwd_addr[0 +: AW] = 5'd7;
    #1 chk("loaduse_allow_in", 32'(id_allow_in), 32'd0);
    step();
    fwd_ready = 3'b001; fwd_data[0 +: XL] = 32'h1234;
    #1 chk("loaduse_rs2", out_rs2, 32'h1234);
    step();
    idle();
    #1 chk("loaduse_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("loaduse_hazard_cnt", 32'(hazard_cnt), 32'd1);
    step();

    // x0 source: never forwarded, never a hazard
    fetch(32'h30, 32'h0000_0093);
    idle(); rs2_en = 1'b0;
    fwd_valid = 3'b001; fwd_we = 3'b001;
    #1 chk("x0_rs1", out_rs1, 32'd0);
    chk("x0_issue", 32'(out_valid), 32'd1);
    step();

    // Stalled instruction flushed; fetch presented with the flush is dropped
    fetch(32'h40, 32'h0070_00B3);
    idle();
    fwd_valid = 3'b001; fwd_we = 3'b001; fwd_addr[0 +: AW] = 5'd7;
    step();
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h80; in_inst = 32'h0020_81B3;
    #1 chk("flush_out_valid", 32'(out_valid), 32'd0);
    step();
    idle();
    #1 chk("flush_not_captured", id_pc, 32'h40);
    chk("flush_allow_in", 32'(id_allow_in), 32'd1);
    step();

    // Hold long enough to saturate, then clear under hold
    idle(); clr_cnt = 1'b1; step();
    fetch(32'h50, 32'h0020_81B3);
    idle(); hold = 1'b1;
    for (int k = 0; k < (1 << CW) + 3; k++) step();
    #1 chk("stall_saturated", 32'(stall_cnt), 32'(CMAX));
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    #1 chk("clr_under_hold", 32'(stall_cnt), 32'd0);
    step();
    idle();
    step();

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      in_valid     = ($urandom_range(0, 9) < 7);
      in_pc        = $urandom & 32'hFFFF_FFFC;
      inst         = $urandom;
      inst[19:15]  = 5'($urandom_range(0, 3));
      inst[24:20]  = 5'($urandom_range(0, 3));
      in_inst      = inst;
      rs1_en       = ($urandom_range(0, 9) != 0);
      rs2_en       = ($urandom_range(0, 9) < 7);
      hold         = ($urandom_range(0, 9) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      out_allow_in = ($urandom_range(0, 9) < 8);
      clr_cnt      = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NF; i++) begin
        fwd_valid[i]          = ($urandom_range(0, 9) < 6);
        fwd_we[i]             = ($urandom_range(0, 9) < 7);
        fwd_ready[i]          = ($urandom_range(0, 9) < 7);
        fwd_addr[i*AW +: AW]  = 5'($urandom_range(0, 3));
        fwd_data[i*XL +: XL]  = $urandom;
      end
      step();
    end

    idle();
    step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
